// File: rtl/mips_cache_pkg.sv
// Shared definitions for the MIPS cache/memory interface slice.
//   arb_state_t          : Avalon arbiter state encoding (also on the debug port)
//   STARVE_LIMIT_DEFAULT : read grants a pending write may lose before it wins
//   REQ_I/REQ_D/REQ_W    : bit positions of the requesters in req/grant vectors
package mips_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_GRANT_W = 2'd3
    } arb_state_t;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    localparam int unsigned REQ_I = 0;
    localparam int unsigned REQ_D = 1;
    localparam int unsigned REQ_W = 2;

endpackage

// File: rtl/mips_avalon_arb_pick.sv
// Combinational winner selection for the Avalon arbiter.
//   reqs   [2:0] : eligible requests, indexed by REQ_I/REQ_D/REQ_W
//   w_full       : write buffer full, forces the write to the front
//   streak [2:0] : consecutive read grants while a write was waiting
//   grant  [2:0] : one-hot winner, all zero when nothing is eligible
module mips_avalon_arb_pick
    import mips_cache_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic [2:0] reqs,
    input  logic       w_full,
    input  logic [2:0] streak,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (reqs[REQ_W] && (w_full || streak == 3'(STARVE_LIMIT))) begin
            grant[REQ_W] = 1'b1;
        end else if (reqs[REQ_I]) begin
            grant[REQ_I] = 1'b1;
        end else if (reqs[REQ_D]) begin
            grant[REQ_D] = 1'b1;
        end else if (reqs[REQ_W]) begin
            grant[REQ_W] = 1'b1;
        end
    end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Three-way arbiter (instruction fetch, data line fill, write-buffer drain)
// onto a single Avalon-MM master. One transaction at a time, no preemption,
// all outputs registered.
//   clk, rst                      : clock, asynchronous active-low reset
//   i_req/i_addr -> i_ack/i_rdata : instruction read port
//   d_req/d_addr -> d_ack/d_rdata : data read port
//   w_req/w_addr/w_wdata/w_byteen/w_full -> w_ack : write port
//   mem_* , waitrequest, mem_readdata : Avalon master
//   arb_state                     : current state (debug)
module mips_avalon_arbiter
    import mips_cache_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic        w_req,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_wdata,
    input  logic [3:0]  w_byteen,
    input  logic        w_full,
    output logic        w_ack,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    input  logic        waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [1:0]  arb_state
);

    arb_state_t  state_q, state_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        w_ack_q, w_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [2:0]  streak_q, streak_d;

    logic [2:0]  reqs;
    logic [2:0]  grant;

    // A requester acked this cycle still holds req until it sees the ack;
    // masking it here prevents granting the same request twice.
    assign reqs = {w_req & ~w_ack_q, d_req & ~d_ack_q, i_req & ~i_ack_q};

    mips_avalon_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .reqs   (reqs),
        .w_full (w_full),
        .streak (streak_q),
        .grant  (grant)
    );

    always_comb begin
        state_d          = state_q;
        mem_address_d    = mem_address_q;
        mem_writedata_d  = mem_writedata_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_byteenable_d = mem_byteenable_q;
        i_ack_d          = 1'b0;
        d_ack_d          = 1'b0;
        w_ack_d          = 1'b0;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        streak_d         = w_req ? streak_q : '0;

        case (state_q)
            ST_IDLE: begin
                if (grant[REQ_W]) begin
                    state_d          = ST_GRANT_W;
                    mem_address_d    = w_addr;
                    mem_writedata_d  = w_wdata;
                    mem_byteenable_d = w_byteen;
                    mem_write_d      = 1'b1;
                    streak_d         = '0;
                end else if (grant[REQ_I] || grant[REQ_D]) begin
                    state_d          = grant[REQ_I] ? ST_GRANT_I : ST_GRANT_D;
                    mem_address_d    = grant[REQ_I] ? i_addr : d_addr;
                    mem_writedata_d  = '0;
                    mem_byteenable_d = '1;
                    mem_read_d       = 1'b1;
                    if (w_req && streak_q < 3'(STARVE_LIMIT)) begin
                        streak_d = streak_q + 3'd1;
                    end
                end
            end
            ST_GRANT_I, ST_GRANT_D, ST_GRANT_W: begin
                if (!waitrequest) begin
                    state_d     = ST_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    case (state_q)
                        ST_GRANT_I: begin
                            i_ack_d   = 1'b1;
                            i_rdata_d = mem_readdata;
                        end
                        ST_GRANT_D: begin
                            d_ack_d   = 1'b1;
                            d_rdata_d = mem_readdata;
                        end
                        default: w_ack_d = 1'b1;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            mem_address_q    <= '0;
            mem_writedata_q  <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_byteenable_q <= '0;
            i_ack_q          <= 1'b0;
            d_ack_q          <= 1'b0;
            w_ack_q          <= 1'b0;
            i_rdata_q        <= '0;
            d_rdata_q        <= '0;
            streak_q         <= '0;
        end else begin
            state_q          <= state_d;
            mem_address_q    <= mem_address_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_byteenable_q <= mem_byteenable_d;
            i_ack_q          <= i_ack_d;
            d_ack_q          <= d_ack_d;
            w_ack_q          <= w_ack_d;
            i_rdata_q        <= i_rdata_d;
            d_rdata_q        <= d_rdata_d;
            streak_q         <= streak_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = mem_byteenable_q;
    assign i_ack          = i_ack_q;
    assign d_ack          = d_ack_q;
    assign w_ack          = w_ack_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign arb_state      = state_q;

    // A granted requester must hold its request until acked.
    a_i_held: assert property (@(posedge clk) disable iff (!rst) (state_q == ST_GRANT_I) |-> i_req);
    a_d_held: assert property (@(posedge clk) disable iff (!rst) (state_q == ST_GRANT_D) |-> d_req);
    a_w_held: assert property (@(posedge clk) disable iff (!rst) (state_q == ST_GRANT_W) |-> w_req);

endmodule
